// File: rtl/br_resolve_ctrl.sv
// Branch resolution for the execute stage: evaluates the RV32 compare, decides taken/target, flags mispredicts.
// Latency: an op accepted on edge k presents its result from edge k+1 (s1 operands -> s2 result), 1 op/cycle.
// Backpressure: s2 holds while commit stalls; s1 still fills, then o_ready drops; flush blocks intake for one cycle.
module br_resolve_ctrl #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4,
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [XLEN-1:0]  i_pc,
    input  logic [XLEN-1:0]  i_imm,
    input  logic [XLEN-1:0]  i_rs1_data,
    input  logic [XLEN-1:0]  i_rs2_data,
    input  logic [2:0]       i_funct3,
    input  logic             i_is_jal,
    input  logic             i_is_jalr,
    input  logic             i_pred_taken,
    input  logic [XLEN-1:0]  i_pred_target,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic             o_taken,
    output logic [XLEN-1:0]  o_redirect_pc,
    output logic             o_mispredict,
    output logic             o_illegal,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_flush,
    output logic [CNT_W-1:0] o_br_cnt,
    output logic [CNT_W-1:0] o_mis_cnt
);

    // s1 operand register
    logic             s1_valid;
    logic [XLEN-1:0]  s1_pc;
    logic [XLEN-1:0]  s1_imm;
    logic [XLEN-1:0]  s1_rs1;
    logic [XLEN-1:0]  s1_rs2;
    logic [2:0]       s1_funct3;
    logic             s1_is_jal;
    logic             s1_is_jalr;
    logic             s1_pred_taken;
    logic [XLEN-1:0]  s1_pred_target;
    logic [TAG_W-1:0] s1_tag;

    // resolution results computed from s1
    logic             eq;
    logic             lt_s;
    logic             lt_u;
    logic             taken;
    logic             illegal;
    logic [XLEN-1:0]  target;
    logic [XLEN-1:0]  redirect;
    logic             mispredict;

    logic res_hs;
    logic s1_move;
    logic accept;

    // Handshake and stage-advance control; a flush kills the op in s1 and blocks intake
    always_comb begin
        res_hs  = o_res_valid && i_res_ready;
        o_flush = res_hs && o_mispredict;
        s1_move = s1_valid && (!o_res_valid || i_res_ready) && !o_flush;
        o_ready = (!s1_valid || s1_move) && !o_flush;
        accept  = i_valid && o_ready;
    end

    // Compare, taken decode, target and mispredict evaluation on s1 operands
    always_comb begin
        eq      = (s1_rs1 == s1_rs2);
        lt_s    = ($signed(s1_rs1) < $signed(s1_rs2));
        lt_u    = (s1_rs1 < s1_rs2);
        taken   = 1'b0;
        illegal = 1'b0;
        if (s1_is_jal || s1_is_jalr) begin
            taken = 1'b1;
        end else begin
            case (s1_funct3)
                3'b000:  taken = eq;
                3'b001:  taken = !eq;
                3'b100:  taken = lt_s;
                3'b101:  taken = !lt_s;
                3'b110:  taken = lt_u;
                3'b111:  taken = !lt_u;
                default: illegal = 1'b1;
            endcase
        end
        // jalr wins when both jump flags are set
        if (s1_is_jalr) begin
            target = (s1_rs1 + s1_imm) & ~XLEN'(1);
        end else begin
            target = s1_pc + s1_imm;
        end
        redirect   = taken ? target : (s1_pc + XLEN'(4));
        mispredict = (taken != s1_pred_taken) ||
                     (taken && s1_pred_taken && (target != s1_pred_target));
    end

    // s1 operand register: load on accept, clear when it drains or is flushed
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid       <= 1'b0;
            s1_pc          <= '0;
            s1_imm         <= '0;
            s1_rs1         <= '0;
            s1_rs2         <= '0;
            s1_funct3      <= '0;
            s1_is_jal      <= 1'b0;
            s1_is_jalr     <= 1'b0;
            s1_pred_taken  <= 1'b0;
            s1_pred_target <= '0;
            s1_tag         <= '0;
        end else begin
            if (o_flush) begin
                s1_valid <= 1'b0;
            end else if (accept) begin
                s1_valid <= 1'b1;
            end else if (s1_move) begin
                s1_valid <= 1'b0;
            end
            if (accept) begin
                s1_pc          <= i_pc;
                s1_imm         <= i_imm;
                s1_rs1         <= i_rs1_data;
                s1_rs2         <= i_rs2_data;
                s1_funct3      <= i_funct3;
                s1_is_jal      <= i_is_jal;
                s1_is_jalr     <= i_is_jalr;
                s1_pred_taken  <= i_pred_taken;
                s1_pred_target <= i_pred_target;
                s1_tag         <= i_tag;
            end
        end
    end

    // s2 result register: fields only change when a new op moves in, so they hold under stall
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_res_valid   <= 1'b0;
            o_taken       <= 1'b0;
            o_redirect_pc <= '0;
            o_mispredict  <= 1'b0;
            o_illegal     <= 1'b0;
            o_tag         <= '0;
        end else begin
            if (s1_move) begin
                o_res_valid   <= 1'b1;
                o_taken       <= taken;
                o_redirect_pc <= redirect;
                o_mispredict  <= mispredict;
                o_illegal     <= illegal;
                o_tag         <= s1_tag;
            end else if (res_hs) begin
                o_res_valid   <= 1'b0;
            end
        end
    end

    // Performance counters, advanced on each result handshake, wrapping naturally
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_br_cnt  <= '0;
            o_mis_cnt <= '0;
        end else if (res_hs) begin
            o_br_cnt <= o_br_cnt + CNT_W'(1);
            if (o_mispredict) begin
                o_mis_cnt <= o_mis_cnt + CNT_W'(1);
            end
        end
    end

endmodule
